rv_multi_cycle_control: RTL and testbench
=========================================

RV_MULTI_CYCLE_CONTROL -- requirements
Module: rv_multi_cycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum Mem_Ready_i wait cycles per memory state before trap.
REQ-002 SHALL have parameter MUL_LATENCY, default 4: cycles spent in MUL_WAIT (used only when RV_MUL_EN is defined).
REQ-003 SHALL have ports clk input 1 (system clock) and reset input 1. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports OP_i input 7, funct3_i input 3, funct7_i input 7: decoded from the latched instruction register.
REQ-005 SHALL have ports Mem_Ready_i input 1 (memory access complete) and Zero_i input 1 (ALU zero flag).
REQ-006 SHALL have outputs Mem_Req_o 1, Mem_Write_o 1, Adr_Src_o 1 (0=PC, 1=ALU result register) and IR_Write_o 1.
REQ-007 SHALL have outputs PC_Write_o 1, Reg_Write_o 1, ALU_Src_A_o 2 (00 PC, 01 old PC, 10 rs1) and ALU_Src_B_o 2 (00 rs2, 01 imm, 10 const 4).
REQ-008 SHALL have outputs ALU_Op_o 3 (000 add, 001 sub, 010 R-funct, 011 I-funct), Result_Src_o 2 (00 ALU reg, 01 mem data, 10 ALU direct, 11 multiplier) and Mul_Start_o 1.
REQ-009 SHALL have outputs Trap_o 1, Trap_Cause_o 2 (01 illegal opcode, 10 memory timeout) and State_o 4 (current state, debug).

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BEQ, JAL, TRAP, MUL_WAIT.
REQ-011 IDLE: all outputs 0; SHALL go to FETCH on the next clock.
REQ-012 FETCH: Mem_Req_o=1, Adr_Src_o=0, ALU_Src_A_o=00, ALU_Src_B_o=10, ALU_Op_o=000, Result_Src_o=10; IR_Write_o and PC_Write_o SHALL pulse only in the cycle Mem_Ready_i=1, then go to DECODE; otherwise stay.
REQ-013 DECODE: ALU_Src_A_o=01, ALU_Src_B_o=01, ALU_Op_o=000 (branch target); next state by OP_i: 0000011/0100011 to MEM_ADR, 0110011 to EXEC_R, 0010011 to EXEC_I, 1100011 to BEQ, 1101111 to JAL, any other opcode to TRAP with cause 01.
REQ-014 MEM_ADR: rs1+imm; to MEM_RD if OP_i=0000011, else MEM_WR.
REQ-015 MEM_RD/MEM_WR: Mem_Req_o=1, Adr_Src_o=1, Mem_Write_o=1 in MEM_WR only; on Mem_Ready_i go to MEM_WB or FETCH respectively.
REQ-016 MEM_WB: Result_Src_o=01, Reg_Write_o=1; then FETCH.
REQ-017 EXEC_R: rs1 op rs2, ALU_Op_o=010; EXEC_I: rs1 op imm, ALU_Op_o=011; both to ALU_WB, which drives Result_Src_o=00, Reg_Write_o=1, then FETCH.
REQ-018 BEQ: ALU_Src_A_o=10, ALU_Src_B_o=00, ALU_Op_o=001, Result_Src_o=00; PC_Write_o=Zero_i; then FETCH.
REQ-019 JAL: ALU_Src_A_o=01, ALU_Src_B_o=10, Result_Src_o=00, PC_Write_o=1; then ALU_WB.
REQ-020 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle Mem_Ready_i=0; reaching MEM_TIMEOUT goes to TRAP with cause 10; Mem_Ready_i in the same cycle as the limit SHALL win.
REQ-021 TRAP: Trap_o=1, Trap_Cause_o held, all write/request outputs 0; sticky until reset.
REQ-022 Mem_Ready_i outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-023 Reset low SHALL asynchronously force IDLE, clear wait/mul counters, Trap_Cause_o=00 and all outputs 0, including reset asserted mid memory wait.

Configuration
REQ-024 With RV_MUL_EN defined: OP_i=0110011 and funct7_i=0000001 SHALL go DECODE to MUL_WAIT, pulse Mul_Start_o on the first MUL_WAIT cycle, stay MUL_LATENCY cycles, then ALU_WB with Result_Src_o=11.
REQ-025 Without RV_MUL_EN: that encoding SHALL go to TRAP cause 01; no multiplier counter SHALL be synthesised.

Structure
REQ-026 State encoding, opcode constants, ALU_Op/Result_Src/source-select encodings and trap causes SHALL live in shared package rv_ctrl_pkg.
REQ-027 The timeout counter SHALL be one sub-module, rv_wait_timer (clear, enable, limit-reached).

Verification
REQ-028 add x3,x1,x2 with Mem_Ready_i=1 every cycle -> IDLE,FETCH,DECODE,EXEC_R,ALU_WB,FETCH; one Reg_Write_o pulse.
REQ-029 lw with Mem_Ready_i delayed 3 cycles in MEM_RD -> 3 extra MEM_RD cycles, then MEM_WB with Result_Src_o=01.
REQ-030 beq with Zero_i=1 then Zero_i=0 -> PC_Write_o=1 in BEQ once, 0 once.
REQ-031 Mem_Ready_i held 0 in FETCH, MEM_TIMEOUT=16 -> TRAP after 16 wait cycles, Trap_Cause_o=10; ready on cycle 16 -> DECODE instead.
REQ-032 OP_i=1111111 -> TRAP cause 01; reset low mid-TRAP -> IDLE immediately, outputs 0.
REQ-033 mul with RV_MUL_EN, MUL_LATENCY=4 -> Mul_Start_o one cycle, 4 MUL_WAIT cycles, ALU_WB Result_Src_o=11; without macro -> TRAP cause 01.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV control unit.
// Holds the state encoding, major opcodes, ALU operation codes,
// result/source select encodings, trap causes and small decode helpers.
package rv_ctrl_pkg;

   // IDLE is encoded as zero so a freshly reset State_o reads all zeros.
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADR  = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALU_WB   = 4'd9,
      S_BEQ      = 4'd10,
      S_JAL      = 4'd11,
      S_TRAP     = 4'd12,
      S_MUL_WAIT = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_RFUNCT = 3'b010;
   localparam logic [2:0] ALU_IFUNCT = 3'b011;

   localparam logic [1:0] RES_ALU_REG = 2'b00;
   localparam logic [1:0] RES_MEM     = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;
   localparam logic [1:0] RES_MUL     = 2'b11;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLD_PC = 2'b01;
   localparam logic [1:0] SRCA_RS1    = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] CAUSE_NONE        = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
   localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

   // R-type opcode with the M-extension funct7 marks a multiply.
   function automatic logic is_mul(input logic [6:0] op, input logic [6:0] f7);
      return (op == OP_RTYPE) && (f7 == F7_MULDIV);
   endfunction

   // States that wait on Mem_Ready_i and are guarded by the timeout timer.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/rv_wait_timer.sv
// Memory wait timer.
// Counts cycles spent waiting for memory and flags the last permitted cycle.
// Ports: clk, reset (async active-low), clear_i (restart from zero, wins
// over enable_i), enable_i (count this cycle), limit_o (count == LIMIT-1,
// i.e. the current cycle is the LIMIT-th wait cycle).
module rv_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic limit_o
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign limit_o = (count_q == W'(LIMIT - 1));

   // Hold at the limit so the counter never wraps back to an early value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !limit_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rv_multi_cycle_control.sv
// Multi-cycle RV32 control FSM.
// Sequences fetch/decode/execute/memory/writeback and raises a sticky trap
// on illegal opcodes or memory timeouts.
// Ports: clk, reset (async active-low); OP_i/funct3_i/funct7_i from the
// instruction register; Mem_Ready_i, Zero_i; memory, register-file, ALU and
// result-mux controls; Mul_Start_o; Trap_o/Trap_Cause_o; State_o (debug).
// Optional feature: define RV_MUL_EN to route multiplies through MUL_WAIT;
// otherwise the multiply encoding traps as illegal.
module rv_multi_cycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int MUL_LATENCY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] OP_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       Mem_Ready_i,
   input  logic       Zero_i,
   output logic       Mem_Req_o,
   output logic       Mem_Write_o,
   output logic       Adr_Src_o,
   output logic       IR_Write_o,
   output logic       PC_Write_o,
   output logic       Reg_Write_o,
   output logic [1:0] ALU_Src_A_o,
   output logic [1:0] ALU_Src_B_o,
   output logic [2:0] ALU_Op_o,
   output logic [1:0] Result_Src_o,
   output logic       Mul_Start_o,
   output logic       Trap_o,
   output logic [1:0] Trap_Cause_o,
   output logic [3:0] State_o
);

   state_t     state_q, state_d;
   logic [1:0] trap_cause_q, trap_cause_d;
   logic       in_mem_state;
   logic       wait_limit;
   logic       unused_funct3;

   // funct3 selects the ALU function in the datapath, not in this FSM.
   assign unused_funct3 = ^funct3_i;

   assign in_mem_state = is_mem_state(state_q);
   assign State_o      = state_q;
   assign Trap_Cause_o = trap_cause_q;

   // Timer restarts whenever the state changes, so every memory state
   // starts its own wait budget.
   rv_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (!in_mem_state || (state_d != state_q)),
      .enable_i (in_mem_state && !Mem_Ready_i),
      .limit_o  (wait_limit)
   );

`ifdef RV_MUL_EN
   localparam int MW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   logic [MW-1:0] mul_cnt_q, mul_cnt_d;
   logic          mul_last;

   assign mul_last = (mul_cnt_q == MW'(MUL_LATENCY - 1));

   // Counts MUL_WAIT cycles; zero on the first cycle marks the start pulse.
   always_comb begin
      mul_cnt_d = '0;
      if (state_q == S_MUL_WAIT && !mul_last) begin
         mul_cnt_d = mul_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_cnt_q <= '0;
      end else begin
         mul_cnt_q <= mul_cnt_d;
      end
   end
`else
   localparam int unused_mul_latency = MUL_LATENCY;
`endif

   // Next-state and Moore/Mealy outputs; trap cause is latched on entry
   // to TRAP and then held until reset.
   always_comb begin
      state_d      = state_q;
      trap_cause_d = trap_cause_q;
      Mem_Req_o    = 1'b0;
      Mem_Write_o  = 1'b0;
      Adr_Src_o    = 1'b0;
      IR_Write_o   = 1'b0;
      PC_Write_o   = 1'b0;
      Reg_Write_o  = 1'b0;
      ALU_Src_A_o  = SRCA_PC;
      ALU_Src_B_o  = SRCB_RS2;
      ALU_Op_o     = ALU_ADD;
      Result_Src_o = RES_ALU_REG;
      Mul_Start_o  = 1'b0;
      Trap_o       = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            Mem_Req_o    = 1'b1;
            ALU_Src_A_o  = SRCA_PC;
            ALU_Src_B_o  = SRCB_FOUR;
            ALU_Op_o     = ALU_ADD;
            Result_Src_o = RES_ALU;
            // Ready in the limit cycle still completes the fetch.
            if (Mem_Ready_i) begin
               IR_Write_o = 1'b1;
               PC_Write_o = 1'b1;
               state_d    = S_DECODE;
            end else if (wait_limit) begin
               state_d      = S_TRAP;
               trap_cause_d = CAUSE_MEM_TIMEOUT;
            end
         end

         S_DECODE: begin
            ALU_Src_A_o = SRCA_OLD_PC;
            ALU_Src_B_o = SRCB_IMM;
            ALU_Op_o    = ALU_ADD;
            case (OP_i)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               OP_RTYPE: begin
                  if (is_mul(OP_i, funct7_i)) begin
`ifdef RV_MUL_EN
                     state_d = S_MUL_WAIT;
`else
                     state_d      = S_TRAP;
                     trap_cause_d = CAUSE_ILLEGAL;
`endif
                  end else begin
                     state_d = S_EXEC_R;
                  end
               end
               default: begin
                  state_d      = S_TRAP;
                  trap_cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end

         S_MEM_ADR: begin
            ALU_Src_A_o = SRCA_RS1;
            ALU_Src_B_o = SRCB_IMM;
            ALU_Op_o    = ALU_ADD;
            state_d     = (OP_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD, S_MEM_WR: begin
            Mem_Req_o   = 1'b1;
            Adr_Src_o   = 1'b1;
            Mem_Write_o = (state_q == S_MEM_WR);
            if (Mem_Ready_i) begin
               state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            end else if (wait_limit) begin
               state_d      = S_TRAP;
               trap_cause_d = CAUSE_MEM_TIMEOUT;
            end
         end

         S_MEM_WB: begin
            Result_Src_o = RES_MEM;
            Reg_Write_o  = 1'b1;
            state_d      = S_FETCH;
         end

         S_EXEC_R: begin
            ALU_Src_A_o = SRCA_RS1;
            ALU_Src_B_o = SRCB_RS2;
            ALU_Op_o    = ALU_RFUNCT;
            state_d     = S_ALU_WB;
         end

         S_EXEC_I: begin
            ALU_Src_A_o = SRCA_RS1;
            ALU_Src_B_o = SRCB_IMM;
            ALU_Op_o    = ALU_IFUNCT;
            state_d     = S_ALU_WB;
         end

         S_ALU_WB: begin
            Result_Src_o = RES_ALU_REG;
            Reg_Write_o  = 1'b1;
`ifdef RV_MUL_EN
            // The instruction register still holds the multiply here.
            if (is_mul(OP_i, funct7_i)) begin
               Result_Src_o = RES_MUL;
            end
`endif
            state_d = S_FETCH;
         end

         S_BEQ: begin
            ALU_Src_A_o  = SRCA_RS1;
            ALU_Src_B_o  = SRCB_RS2;
            ALU_Op_o     = ALU_SUB;
            Result_Src_o = RES_ALU_REG;
            PC_Write_o   = Zero_i;
            state_d      = S_FETCH;
         end

         S_JAL: begin
            ALU_Src_A_o  = SRCA_OLD_PC;
            ALU_Src_B_o  = SRCB_FOUR;
            Result_Src_o = RES_ALU_REG;
            PC_Write_o   = 1'b1;
            state_d      = S_ALU_WB;
         end

         S_TRAP: Trap_o = 1'b1;

`ifdef RV_MUL_EN
         S_MUL_WAIT: begin
            Mul_Start_o = (mul_cnt_q == '0);
            if (mul_last) begin
               state_d = S_ALU_WB;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         trap_cause_q <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         trap_cause_q <= trap_cause_d;
      end
   end

endmodule

// File: tb/tb_rv_multi_cycle_control.sv
// Directed scoreboard bench for rv_multi_cycle_control.
// Each step drives inputs on the falling edge, queues the expected state and
// output vector, then pops and compares shortly afterwards.
module tb_rv_multi_cycle_control;
   import rv_ctrl_pkg::*;

   logic       clk;
   logic       reset;
   logic [6:0] OP_i;
   logic [2:0] funct3_i;
   logic [6:0] funct7_i;
   logic       Mem_Ready_i;
   logic       Zero_i;
   logic       Mem_Req_o, Mem_Write_o, Adr_Src_o, IR_Write_o;
   logic       PC_Write_o, Reg_Write_o, Mul_Start_o, Trap_o;
   logic [1:0] ALU_Src_A_o, ALU_Src_B_o, Result_Src_o, Trap_Cause_o;
   logic [2:0] ALU_Op_o;
   logic [3:0] State_o;

   int checks = 0;
   int errors = 0;

   logic [22:0] expQ[$];
   string       tagQ[$];

   // Order: Req Wr Adr IRW PCW RegW A[2] B[2] Op[3] Res[2] MulStart Trap Cause[2]
   logic [18:0] obsOuts;
   assign obsOuts = {Mem_Req_o, Mem_Write_o, Adr_Src_o, IR_Write_o, PC_Write_o,
                     Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
                     Result_Src_o, Mul_Start_o, Trap_o, Trap_Cause_o};

   localparam logic [18:0] O_IDLE    = 19'b0;
   localparam logic [18:0] O_FETCH_W = {6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_FETCH_R = {6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_DECODE  = {6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_MEM_ADR = {6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_MEM_RD  = {6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_MEM_WR  = {6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_MEM_WB  = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_EXEC_R  = {6'b000000, 2'b10, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_EXEC_I  = {6'b000000, 2'b10, 2'b01, 3'b011, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_ALU_WB  = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_BEQ_T   = {6'b000010, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_BEQ_N   = {6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_JAL     = {6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [18:0] O_TRAP_IL = {6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 2'b01};
   localparam logic [18:0] O_TRAP_TO = {6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 2'b10};
`ifdef RV_MUL_EN
   localparam logic [18:0] O_MUL_S   = {6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 2'b00};
   localparam logic [18:0] O_ALU_WBM = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0, 2'b00};
`endif

   rv_multi_cycle_control #(
      .MEM_TIMEOUT (16),
      .MUL_LATENCY (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .OP_i         (OP_i),
      .funct3_i     (funct3_i),
      .funct7_i     (funct7_i),
      .Mem_Ready_i  (Mem_Ready_i),
      .Zero_i       (Zero_i),
      .Mem_Req_o    (Mem_Req_o),
      .Mem_Write_o  (Mem_Write_o),
      .Adr_Src_o    (Adr_Src_o),
      .IR_Write_o   (IR_Write_o),
      .PC_Write_o   (PC_Write_o),
      .Reg_Write_o  (Reg_Write_o),
      .ALU_Src_A_o  (ALU_Src_A_o),
      .ALU_Src_B_o  (ALU_Src_B_o),
      .ALU_Op_o     (ALU_Op_o),
      .Result_Src_o (Result_Src_o),
      .Mul_Start_o  (Mul_Start_o),
      .Trap_o       (Trap_o),
      .Trap_Cause_o (Trap_Cause_o),
      .State_o      (State_o)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic setInstr(input logic [6:0] op, input logic [6:0] f7);
      OP_i     = op;
      funct3_i = 3'b000;
      funct7_i = f7;
   endtask

   task automatic applyStimulus(input string tag, input logic rdy, input logic zero,
                                input state_t st, input logic [18:0] outs);
      Mem_Ready_i = rdy;
      Zero_i      = zero;
      expQ.push_back({4'(st), outs});
      tagQ.push_back(tag);
   endtask

   task automatic checkOutput();
      logic [22:0] e;
      string       t;
      #1;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
         return;
      end
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checks++;
      assert (State_o === e[22:19]) else begin
         errors++;
         $error("[TB] FAIL %s state observed=%0d expected=%0d", t, State_o, e[22:19]);
      end
      checks++;
      assert (obsOuts === e[18:0]) else begin
         errors++;
         $error("[TB] FAIL %s outputs observed=%b expected=%b", t, obsOuts, e[18:0]);
      end
   endtask

   task automatic doStep(input string tag, input logic rdy, input logic zero,
                         input state_t st, input logic [18:0] outs);
      applyStimulus(tag, rdy, zero, st, outs);
      checkOutput();
      @(negedge clk);
   endtask

   // Drops reset on a falling edge and checks IDLE before any rising edge.
   task automatic resetCheck(input string tag);
      reset = 1'b0;
      applyStimulus(tag, 1'b1, 1'b0, S_IDLE, O_IDLE);
      checkOutput();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      Mem_Ready_i = 1'b0;
      Zero_i = 1'b0;
      setInstr(OP_RTYPE, 7'b0000000);
      #1 reset = 1'b0;
      @(negedge clk);
      applyStimulus("reset_state", 1'b0, 1'b0, S_IDLE, O_IDLE);
      checkOutput();
      reset = 1'b1;
      doStep("idle_ignores_ready", 1, 0, S_IDLE, O_IDLE);

      // add x3,x1,x2
      doStep("add_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("add_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("add_exec_r", 1, 0, S_EXEC_R, O_EXEC_R);
      doStep("add_alu_wb", 1, 0, S_ALU_WB, O_ALU_WB);

      // lw with three ready-low cycles in MEM_RD
      setInstr(OP_LOAD, 7'b0);
      doStep("lw_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("lw_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("lw_mem_adr", 1, 0, S_MEM_ADR, O_MEM_ADR);
      for (int i = 0; i < 3; i++) doStep("lw_mem_rd_wait", 0, 0, S_MEM_RD, O_MEM_RD);
      doStep("lw_mem_rd_done", 1, 0, S_MEM_RD, O_MEM_RD);
      doStep("lw_mem_wb", 1, 0, S_MEM_WB, O_MEM_WB);

      // sw
      setInstr(OP_STORE, 7'b0);
      doStep("sw_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("sw_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("sw_mem_adr", 1, 0, S_MEM_ADR, O_MEM_ADR);
      doStep("sw_mem_wr_wait", 0, 0, S_MEM_WR, O_MEM_WR);
      doStep("sw_mem_wr_done", 1, 0, S_MEM_WR, O_MEM_WR);

      // beq taken then not taken
      setInstr(OP_BRANCH, 7'b0);
      doStep("beq1_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("beq1_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("beq_taken", 1, 1, S_BEQ, O_BEQ_T);
      doStep("beq2_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("beq2_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("beq_not_taken", 1, 0, S_BEQ, O_BEQ_N);

      // jal
      setInstr(OP_JAL, 7'b0);
      doStep("jal_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("jal_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("jal_exec", 1, 0, S_JAL, O_JAL);
      doStep("jal_alu_wb", 1, 0, S_ALU_WB, O_ALU_WB);

      // addi, ready arrives exactly on the 16th fetch cycle
      setInstr(OP_ITYPE, 7'b0);
      for (int i = 0; i < 15; i++) doStep("fetch_wait_edge", 0, 0, S_FETCH, O_FETCH_W);
      doStep("fetch_ready_at_limit", 1, 0, S_FETCH, O_FETCH_R);
      doStep("addi_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("addi_exec_i", 1, 0, S_EXEC_I, O_EXEC_I);
      doStep("addi_alu_wb", 1, 0, S_ALU_WB, O_ALU_WB);

      // mul encoding
      setInstr(OP_RTYPE, 7'b0000001);
      doStep("mul_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("mul_decode", 1, 0, S_DECODE, O_DECODE);
`ifdef RV_MUL_EN
      doStep("mul_start", 1, 0, S_MUL_WAIT, O_MUL_S);
      for (int i = 0; i < 3; i++) doStep("mul_wait", 1, 0, S_MUL_WAIT, O_IDLE);
      doStep("mul_alu_wb", 1, 0, S_ALU_WB, O_ALU_WBM);
      doStep("mul_next_fetch", 0, 0, S_FETCH, O_FETCH_W);
`else
      doStep("mul_trap", 1, 0, S_TRAP, O_TRAP_IL);
      doStep("mul_trap_sticky", 1, 0, S_TRAP, O_TRAP_IL);
`endif
      resetCheck("reset_after_mul");

      // illegal opcode, then reset in the middle of TRAP
      setInstr(7'b1111111, 7'b0);
      doStep("ill_idle", 1, 0, S_IDLE, O_IDLE);
      doStep("ill_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("ill_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("ill_trap", 1, 0, S_TRAP, O_TRAP_IL);
      doStep("ill_trap_sticky", 1, 0, S_TRAP, O_TRAP_IL);
      resetCheck("reset_mid_trap");

      // fetch timeout
      setInstr(OP_ITYPE, 7'b0);
      doStep("to_idle", 0, 0, S_IDLE, O_IDLE);
      for (int i = 0; i < 16; i++) doStep("fetch_wait_timeout", 0, 0, S_FETCH, O_FETCH_W);
      doStep("fetch_timeout_trap", 0, 0, S_TRAP, O_TRAP_TO);
      doStep("fetch_timeout_sticky", 1, 0, S_TRAP, O_TRAP_TO);
      resetCheck("reset_after_timeout");

      // reset during a memory wait, then a full MEM_RD timeout
      setInstr(OP_LOAD, 7'b0);
      doStep("lw2_idle", 1, 0, S_IDLE, O_IDLE);
      doStep("lw2_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("lw2_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("lw2_mem_adr", 1, 0, S_MEM_ADR, O_MEM_ADR);
      for (int i = 0; i < 2; i++) doStep("lw2_mem_rd_wait", 0, 0, S_MEM_RD, O_MEM_RD);
      resetCheck("reset_mid_mem_wait");
      doStep("lw3_idle", 1, 0, S_IDLE, O_IDLE);
      doStep("lw3_fetch", 1, 0, S_FETCH, O_FETCH_R);
      doStep("lw3_decode", 1, 0, S_DECODE, O_DECODE);
      doStep("lw3_mem_adr", 1, 0, S_MEM_ADR, O_MEM_ADR);
      for (int i = 0; i < 16; i++) doStep("lw3_mem_rd_wait", 0, 0, S_MEM_RD, O_MEM_RD);
      doStep("mem_rd_timeout_trap", 0, 0, S_TRAP, O_TRAP_TO);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
